// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its byte packer.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  function automatic int byte_idx_width(input int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first accepted byte ends up in the word's top byte.
module byte_packer
  import mips_loader_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  Res,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic                  word_full,
  output logic [Data_Width-1:0] packed_word
);

  localparam int BPW  = Data_Width / 8;
  localparam int IDXW = byte_idx_width(Data_Width);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  logic [IDXW-1:0]       byte_cnt;
  logic [Data_Width-9:0] shift;

  // The word is complete combinationally on the last byte so the write can follow next cycle.
  assign packed_word = {shift, byte_in};
  assign word_full   = accept && (byte_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!Res) begin
      byte_cnt <= {IDXW{1'b0}};
      shift    <= {(Data_Width-8){1'b0}};
    end else if (clear) begin
      byte_cnt <= {IDXW{1'b0}};
      shift    <= {(Data_Width-8){1'b0}};
    end else if (accept) begin
      shift    <= packed_word[Data_Width-9:0];
      byte_cnt <= word_full ? {IDXW{1'b0}} : byte_cnt + IDX_ONE;
    end else begin
      byte_cnt <= byte_cnt;
      shift    <= shift;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them, then releases the core.
// Optional trailing-checksum check is enabled with `define LOADER_CHECKSUM_EN.
module instr_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int Data_Width = 32,
  parameter int AD_Width   = 8
) (
  input  logic                  clk,
  input  logic                  Res,
  input  logic                  start,
  input  logic [AD_Width:0]     Num_Words,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  output logic                  Wr_En,
  output logic [AD_Width-1:0]   Wr_Addr,
  output logic [Data_Width-1:0] Wr_Data,
  output logic                  Cpu_Res,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Chk_Err
);

  localparam logic [AD_Width:0]   MAX_WORDS = {1'b1, {AD_Width{1'b0}}};
  localparam logic [AD_Width:0]   ONE_WORD  = {{AD_Width{1'b0}}, 1'b1};
  localparam logic [AD_Width:0]   NO_WORDS  = {(AD_Width+1){1'b0}};
  localparam logic [AD_Width-1:0] ADDR_ONE  = AD_Width'(1);

  state_t                state;
  state_t                next_state;
  logic [AD_Width:0]     n_words;
  logic [AD_Width:0]     num_clamped;
  logic [AD_Width-1:0]   word_cnt;
  logic                  restart;
  logic                  accept;
  logic                  load_accept;
  logic                  word_full;
  logic                  last_word;
  logic [Data_Width-1:0] packed_word;
  logic                  byte_ready_nxt;
  logic                  wr_en_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  cpu_res_nxt;

  assign restart     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign num_clamped = (Num_Words > MAX_WORDS) ? MAX_WORDS : Num_Words;
  assign accept      = Byte_Valid && Byte_Ready;
  assign load_accept = accept && (state == ST_LOAD);
  assign last_word   = ({1'b0, word_cnt} == (n_words - ONE_WORD));

  byte_packer #(
    .Data_Width (Data_Width)
  ) u_packer (
    .clk         (clk),
    .Res         (Res),
    .clear       (restart),
    .accept      (load_accept),
    .byte_in     (Byte_In),
    .word_full   (word_full),
    .packed_word (packed_word)
  );

  always_ff @(posedge clk) begin
    if (!Res) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (restart) begin
          next_state = (num_clamped == NO_WORDS) ? ST_DONE : ST_LOAD;
        end else begin
          next_state = state;
        end
      end
      ST_LOAD: begin
        if (word_full) begin
          next_state = ST_WRITE;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = ST_CHECK;
`else
          next_state = ST_DONE;
`endif
        end else begin
          next_state = ST_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_CHECK;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       chk_err;
  logic       chk_err_nxt;

  // The trailing byte is the only one compared; data bytes feed the running XOR.
  always_ff @(posedge clk) begin
    if (!Res) begin
      csum    <= 8'h00;
      chk_err <= 1'b0;
    end else begin
      chk_err <= chk_err_nxt;
      if (restart) begin
        csum <= 8'h00;
      end else if (load_accept) begin
        csum <= csum ^ Byte_In;
      end else begin
        csum <= csum;
      end
    end
  end

  assign Chk_Err = chk_err;
`else
  assign Chk_Err = 1'b0;
`endif

  // Outputs are decoded from the next state so they register in step with the state.
  always_comb begin
    byte_ready_nxt = (next_state == ST_LOAD) || (next_state == ST_CHECK);
    wr_en_nxt      = (next_state == ST_WRITE);
    busy_nxt       = (next_state == ST_LOAD) || (next_state == ST_WRITE) ||
                     (next_state == ST_CHECK);
    done_nxt       = (next_state == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
    chk_err_nxt = chk_err;
    if (restart) begin
      chk_err_nxt = 1'b0;
    end else if ((state == ST_CHECK) && accept) begin
      chk_err_nxt = (Byte_In != csum);
    end else begin
      chk_err_nxt = chk_err;
    end
    cpu_res_nxt = done_nxt && !chk_err_nxt;
`else
    cpu_res_nxt = done_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!Res) begin
      Byte_Ready <= 1'b0;
      Wr_En      <= 1'b0;
      Wr_Addr    <= {AD_Width{1'b0}};
      Wr_Data    <= {Data_Width{1'b0}};
      Cpu_Res    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      n_words    <= NO_WORDS;
      word_cnt   <= {AD_Width{1'b0}};
    end else begin
      Byte_Ready <= byte_ready_nxt;
      Wr_En      <= wr_en_nxt;
      Busy       <= busy_nxt;
      Done       <= done_nxt;
      Cpu_Res    <= cpu_res_nxt;
      if (wr_en_nxt) begin
        Wr_Addr <= word_cnt;
        Wr_Data <= packed_word;
      end else begin
        Wr_Addr <= Wr_Addr;
        Wr_Data <= Wr_Data;
      end
      // The count stops at the last word, so a full-depth load never wraps.
      if (restart) begin
        n_words  <= num_clamped;
        word_cnt <= {AD_Width{1'b0}};
      end else if ((state == ST_WRITE) && !last_word) begin
        n_words  <= n_words;
        word_cnt <= word_cnt + ADDR_ONE;
      end else begin
        n_words  <= n_words;
        word_cnt <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a queue-based stream model.
module tb_instr_mem_loader;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          Res;
  logic          start;
  logic [AW:0]   Num_Words;
  logic [7:0]    Byte_In;
  logic          Byte_Valid;
  logic          Byte_Ready;
  logic          Wr_En;
  logic [AW-1:0] Wr_Addr;
  logic [DW-1:0] Wr_Data;
  logic          Cpu_Res;
  logic          Busy;
  logic          Done;
  logic          Chk_Err;

  always #5 clk = ~clk;

  instr_mem_loader #(.Data_Width(DW), .AD_Width(AW)) dut (
    .clk(clk), .Res(Res), .start(start), .Num_Words(Num_Words),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Cpu_Res(Cpu_Res),
    .Busy(Busy), .Done(Done), .Chk_Err(Chk_Err)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [7:0]    stream[$];
  logic [DW-1:0] exp_data[$];
  int            exp_addr[$];
  logic [DW-1:0] got [0:255];
  int            hs;
  int            nwr;
  int            n_cur;
  bit            expect_wr;
  bit            exp_err;
  bit            toggle;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Per-cycle comparison against the stream model; called once per negedge during loads.
  task automatic monitor();
    chk("cpu_res_rule", 64'(Cpu_Res), 64'(Done && !Chk_Err));
    chk("busy_done_excl", 64'(Busy && Done), 64'(0));
    chk("wr_en_timing", 64'(Wr_En), 64'(expect_wr));
    expect_wr = 1'b0;
    if (Wr_En) begin
      chk("ready_in_write", 64'(Byte_Ready), 64'(0));
      if (exp_data.size() > 0) begin
        chk("wr_addr", 64'(Wr_Addr), 64'(exp_addr[0]));
        chk("wr_data", 64'(Wr_Data), 64'(exp_data[0]));
        void'(exp_addr.pop_front());
        void'(exp_data.pop_front());
      end
      got[Wr_Addr] = Wr_Data;
      nwr++;
    end
  endtask

  task automatic drive(input int mode, input bit inj);
    bit v;
    case (mode)
      0:       v = 1'b1;
      1:       begin v = toggle; toggle = !toggle; end
      default: v = ($urandom_range(0, 1) == 1);
    endcase
    v = v && (stream.size() > 0);
    Byte_Valid = v;
    Byte_In = v ? stream[0] : 8'($urandom);
    if (v && Byte_Ready) begin
      void'(stream.pop_front());
      hs++;
      if ((hs % 4 == 0) && (hs <= 4 * n_cur)) expect_wr = 1'b1;
    end
    if (inj && (exp_data.size() > 0) && ($urandom_range(0, 15) == 0)) begin
      start = 1'b1;
      Num_Words = 9'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic make_stream(input int n);
    stream.delete();
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic add_trailer(input int n, input bit good);
    exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) begin
      logic [7:0] x;
      x = 8'h00;
      foreach (stream[i]) x ^= stream[i];
      if (good) begin
        stream.push_back(x);
      end else begin
        stream.push_back(x ^ 8'($urandom_range(1, 255)));
        exp_err = 1'b1;
      end
    end
`else
    if ((n > 0) && good) exp_err = 1'b0;
`endif
  endtask

  task automatic do_load(input int num, input int mode, input int stop_hs, input bit inj);
    int n;
    int budget;
    bit seen_done;
    n = (num > 256) ? 256 : num;
    n_cur = n; hs = 0; nwr = 0; expect_wr = 1'b0; toggle = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(w);
      exp_data.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
    end
    @(negedge clk);
    monitor();
    start = 1'b1; Num_Words = 9'(num); Byte_Valid = 1'b0;
    @(negedge clk);
    monitor();
    start = 1'b0;
    chk("start_busy", 64'(Busy), 64'(n != 0));
    chk("start_ready", 64'(Byte_Ready), 64'(n != 0));
    chk("start_done", 64'(Done), 64'(n == 0));
    chk("start_cpu_res", 64'(Cpu_Res), 64'(n == 0));
    seen_done = (n == 0);
    budget = 24 * n + 40;
    while (!seen_done && (budget > 0) && !((stop_hs >= 0) && (hs >= stop_hs))) begin
      drive(mode, inj);
      @(negedge clk);
      monitor();
      seen_done = Done;
      budget--;
    end
    Byte_Valid = 1'b0;
    start = 1'b0;
    if (stop_hs < 0) begin
      chk("done_reached", 64'(seen_done), 64'(1));
      chk("write_count", 64'(nwr), 64'(n));
      chk("stream_consumed", 64'(stream.size()), 64'(0));
      chk("chk_err_final", 64'(Chk_Err), 64'(exp_err));
      chk("cpu_res_final", 64'(Cpu_Res), 64'(!exp_err));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Res = 1'b0; start = 1'b0; Num_Words = '0; Byte_In = 8'h00; Byte_Valid = 1'b0;
    repeat (3) @(negedge clk);
    Res = 1'b1;
    @(negedge clk);
    chk("rst_byte_ready", 64'(Byte_Ready), 64'(0));
    chk("rst_wr_en", 64'(Wr_En), 64'(0));
    chk("rst_wr_addr", 64'(Wr_Addr), 64'(0));
    chk("rst_wr_data", 64'(Wr_Data), 64'(0));
    chk("rst_cpu_res", 64'(Cpu_Res), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_chk_err", 64'(Chk_Err), 64'(0));

    // Two-word load, valid always high, then with valid toggling.
    for (int m = 0; m < 2; m++) begin
      stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
      add_trailer(2, 1'b1);
      do_load(2, m, -1, 1'b0);
      chk("lit_word0", 64'(got[0]), 64'h12345678);
      chk("lit_word1", 64'(got[1]), 64'hABCDEF01);
    end

    // Zero words: done the cycle after start, no writes.
    stream.delete();
    add_trailer(0, 1'b1);
    do_load(0, 0, -1, 1'b0);

    // Oversized count is clamped to the full memory depth.
    make_stream(256);
    add_trailer(256, 1'b1);
    do_load(261, 0, -1, 1'b0);
    chk("clamp_last_addr", 64'(Wr_Addr), 64'(255));

    // Reset in the middle of word 1, then a clean one-word load.
    make_stream(2);
    do_load(2, 0, 6, 1'b0);
    Res = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", 64'(Wr_En), 64'(0));
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_ready", 64'(Byte_Ready), 64'(0));
    chk("abort_done", 64'(Done), 64'(0));
    @(negedge clk);
    Res = 1'b1;
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_trailer(1, 1'b1);
    do_load(1, 0, -1, 1'b0);
    chk("lit_deadbeef", 64'(got[0]), 64'hDEADBEEF);

`ifdef LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    exp_err = 1'b0;
    do_load(1, 0, -1, 1'b0);
    chk("lit_csum_ok", 64'(Chk_Err), 64'(0));
    stream = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00};
    exp_err = 1'b1;
    do_load(1, 0, -1, 1'b0);
    chk("lit_csum_bad", 64'(Cpu_Res), 64'(0));
`endif

    // Random loads with random valid gaps and ignored mid-load start pulses.
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 6);
      make_stream(n);
      add_trailer(n, $urandom_range(0, 1) == 1);
      do_load(n, 2, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
